piece_bag_queue: RTL and testbench

Reader-side companion to `seven_permute`. It drives the permuter's `latch` and `in_val` inputs and collects its seven outputs into a whole bag of pieces 1..7. Bags are stored in a circular queue that serves one current piece and a short preview to the game logic. New bags are refilled automatically whenever the queue has room for seven more entries.

---
 rtl/piece_pkg.sv | 18 +
 rtl/piece_bag_queue_if.sv | 31 +++
 rtl/piece_ring_buffer.sv | 81 ++++++++
 rtl/piece_bag_queue.sv | 116 +++++++++++
 tb/tb_piece_bag_queue.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/piece_pkg.sv
// Shared definitions for the piece bag queue: piece width, bag size,
// the empty-piece code and the refill sequencer state encoding.
package piece_pkg;

  localparam int PIECE_W  = 3;
  localparam int BAG_SIZE = 7;

  typedef logic [PIECE_W-1:0] piece_t;

  localparam piece_t PIECE_NONE = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_READ  = 2'd2
  } refill_state_e;

endpackage

// File: rtl/piece_bag_queue_if.sv
// Handshake bundle between the bag queue, the permuter it reads from and
// the game logic that consumes pieces. master = queue side, slave = user side.
interface piece_bag_queue_if #(
  parameter int PREVIEW = 3
);
  import piece_pkg::*;

  logic                       perm_latch;
  logic [PIECE_W-1:0]         perm_idx;
  logic [PIECE_W-1:0]         perm_val;
  logic                       pop;
  logic [PIECE_W-1:0]         piece;
  logic                       piece_valid;
  logic [PIECE_W*PREVIEW-1:0] preview;
  logic [PREVIEW-1:0]         preview_valid;
  logic [4:0]                 count;
  logic                       bag_err;

  modport master (
    output perm_latch, perm_idx, piece, piece_valid,
    output preview, preview_valid, count, bag_err,
    input  perm_val, pop
  );

  modport slave (
    input  perm_latch, perm_idx, piece, piece_valid,
    input  preview, preview_valid, count, bag_err,
    output perm_val, pop
  );

endinterface

// File: rtl/piece_ring_buffer.sv
// Circular piece store: head/tail pointers, occupancy count, and
// combinational head + preview read ports over the registered storage.
module piece_ring_buffer
  import piece_pkg::*;
#(
  parameter int DEPTH   = 14,
  parameter int PREVIEW = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  piece_t                     wr_data_i,
  input  logic                       pop_i,
  output piece_t                     piece_o,
  output logic                       piece_valid_o,
  output logic [PIECE_W*PREVIEW-1:0] preview_o,
  output logic [PREVIEW-1:0]         preview_valid_o,
  output logic [4:0]                 count_o
);

  localparam int PTR_W = 4;

  piece_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [4:0]       count_q, count_d;
  logic             pop_eff;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy update; a pop on an empty queue is dropped.
  always_comb begin
    pop_eff = pop_i && (count_q != 5'd0);
    head_d  = pop_eff ? ptr_inc(head_q) : head_q;
    tail_d  = wr_en_i ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    case ({wr_en_i, pop_eff})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write at the tail; contents are qualified by count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[tail_q] <= wr_data_i;
    end
  end

  assign count_o       = count_q;
  assign piece_valid_o = (count_q != 5'd0);
  assign piece_o       = piece_valid_o ? mem_q[head_q] : PIECE_NONE;

  // Preview slot k shows entry head+1+k, wrapped modulo DEPTH.
  for (genvar gi = 0; gi < PREVIEW; gi++) begin : g_preview
    logic [4:0]       idx_sum;
    logic [PTR_W-1:0] idx;
    assign idx_sum             = 5'(head_q) + 5'(gi + 1);
    assign idx                 = (idx_sum >= 5'(DEPTH)) ? PTR_W'(idx_sum - 5'(DEPTH))
                                                        : PTR_W'(idx_sum);
    assign preview_valid_o[gi] = (count_q > 5'(gi + 1));
    assign preview_o[gi*PIECE_W +: PIECE_W] = preview_valid_o[gi] ? mem_q[idx] : PIECE_NONE;
  end

endmodule

// File: rtl/piece_bag_queue.sv
// Bag queue top: refill sequencer that reads one permuted bag of pieces
// 1..7 from the permuter whenever seven entries are free, plus the
// per-bag duplicate/zero check. Storage lives in piece_ring_buffer.
module piece_bag_queue
  import piece_pkg::*;
#(
  parameter int DEPTH   = 14,
  parameter int PREVIEW = 3
) (
  input logic               clk,
  input logic               rst,
  piece_bag_queue_if.master bus
);

  refill_state_e state_q, state_d;
  logic [2:0]    rd_cnt_q, rd_cnt_d;
  logic [6:0]    seen_q, seen_d;
  logic          bag_err_q, bag_err_d;

  logic          wr_en;
  logic          perm_latch;
  logic [2:0]    perm_idx;
  logic [6:0]    seen_bit;
  logic          pop_eff;
  logic          piece_valid;
  logic [4:0]    count;

  assign pop_eff = bus.pop & piece_valid;

  // Refill sequencer next state, permuter drive and duplicate tracking.
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    seen_d     = seen_q;
    bag_err_d  = bag_err_q;
    wr_en      = 1'b0;
    perm_latch = 1'b0;
    perm_idx   = '0;
    seen_bit   = (bus.perm_val == PIECE_NONE) ? 7'd0 : (7'd1 << (bus.perm_val - 3'd1));
    case (state_q)
      ST_IDLE: begin
        if ((count <= 5'(DEPTH - BAG_SIZE)) && !pop_eff) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        // The permuter latches on this cycle's negedge, so index 0 is
        // already valid at the closing edge and is written here; READ
        // then covers indices 1..6. The seen-mask restarts with this value.
        perm_latch = 1'b1;
        wr_en      = 1'b1;
        seen_d     = seen_bit;
        if (bus.perm_val == PIECE_NONE) begin
          bag_err_d = 1'b1;
        end
        rd_cnt_d = 3'd1;
        state_d  = ST_READ;
      end
      ST_READ: begin
        perm_idx = rd_cnt_q;
        wr_en    = 1'b1;
        seen_d   = seen_q | seen_bit;
        if ((bus.perm_val == PIECE_NONE) || ((seen_q & seen_bit) != 7'd0)) begin
          bag_err_d = 1'b1;
        end
        if (rd_cnt_q == 3'(BAG_SIZE - 1)) begin
          rd_cnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          rd_cnt_d = rd_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset abandons any partial bag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      seen_q    <= '0;
      bag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      seen_q    <= seen_d;
      bag_err_q <= bag_err_d;
    end
  end

  piece_ring_buffer #(
    .DEPTH   (DEPTH),
    .PREVIEW (PREVIEW)
  ) u_ring (
    .clk             (clk),
    .rst             (rst),
    .wr_en_i         (wr_en),
    .wr_data_i       (bus.perm_val),
    .pop_i           (bus.pop),
    .piece_o         (bus.piece),
    .piece_valid_o   (piece_valid),
    .preview_o       (bus.preview),
    .preview_valid_o (bus.preview_valid),
    .count_o         (count)
  );

  assign bus.piece_valid = piece_valid;
  assign bus.count       = count;
  assign bus.perm_latch  = perm_latch;
  assign bus.perm_idx    = perm_idx;
  assign bus.bag_err     = bag_err_q;

endmodule

// File: tb/tb_piece_bag_queue.sv
// Randomised bench for piece_bag_queue with a behavioural permuter,
// a cycle-level reference queue model and a piece scoreboard.
module tb_piece_bag_queue;
  import piece_pkg::*;

  localparam int DEPTH   = 14;
  localparam int PREVIEW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pop_drv = 1'b0;

  always #5 clk = ~clk;

  piece_bag_queue_if #(.PREVIEW(PREVIEW)) bus ();

  piece_bag_queue #(.DEPTH(DEPTH), .PREVIEW(PREVIEW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural permuter ----------------
  logic [2:0] perm_bag [7];
  int         forced = 1;   // 0 random, 1 fixed 3175264, 2 duplicate 4, 3 contains 0
  int         exp_q[$];     // scoreboard: pieces in the order bags were issued

  assign bus.perm_val = (bus.perm_idx < 3'd7) ? perm_bag[bus.perm_idx] : 3'd0;
  assign bus.pop      = pop_drv;

  task automatic load_bag();
    int tmp[7];
    int j, t;
    case (forced)
      1: tmp = '{3, 1, 7, 5, 2, 6, 4};
      2: tmp = '{2, 4, 1, 4, 6, 7, 3};
      3: tmp = '{5, 0, 1, 2, 3, 4, 6};
      default: begin
        for (int i = 0; i < 7; i++) tmp[i] = i + 1;
        for (int i = 6; i > 0; i--) begin
          j = $urandom_range(i, 0);
          t = tmp[i]; tmp[i] = tmp[j]; tmp[j] = t;
        end
      end
    endcase
    forced = 0;
    for (int i = 0; i < 7; i++) begin
      perm_bag[i] = 3'(tmp[i]);
      exp_q.push_back(tmp[i]);
    end
  endtask

  always @(negedge clk) begin
    if (bus.perm_latch === 1'b1) load_bag();
  end

  // ---------------- reference model ----------------
  // mq: queue contents; left: writes still owed by the current refill
  // (7 during the latch cycle, then counting down); merr: sticky bag error.
  int mq[$];
  int left = 0;
  bit merr = 0;
  bit mseen[8];
  bit started = 0;
  bit pe;
  int v;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      left = 0;
      merr = 0;
    end else begin
      pe = pop_drv && (mq.size() > 0);
      if (left > 0) begin
        v = int'(perm_bag[7 - left]);
        if (left == 7) for (int i = 0; i < 8; i++) mseen[i] = 0;
        if (v == 0 || mseen[v]) merr = 1;
        mseen[v] = 1;
        left--;
        if (pe) void'(mq.pop_front());
        mq.push_back(v);
      end else begin
        if (mq.size() <= DEPTH - 7 && !pe) left = 7;
        if (pe) void'(mq.pop_front());
      end
    end
  end

  // Cycle checker: every registered-visible output against the model.
  always @(negedge clk) begin
    if (started) begin
      check("count", 32'(bus.count), 32'(mq.size()));
      check("piece_valid", 32'(bus.piece_valid), 32'(mq.size() > 0));
      check("piece", 32'(bus.piece), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
      for (int k = 0; k < PREVIEW; k++) begin
        check("preview", 32'(bus.preview[3*k +: 3]), (mq.size() > k + 1) ? 32'(mq[k+1]) : 32'd0);
        check("preview_valid", 32'(bus.preview_valid[k]), 32'(mq.size() > k + 1));
      end
      check("perm_latch", 32'(bus.perm_latch), 32'(left == 7));
      check("perm_idx", 32'(bus.perm_idx), (left > 0) ? 32'(7 - left) : 32'd0);
      check("bag_err", 32'(bus.bag_err), 32'(merr));
    end
  end

  // Scoreboard monitor: every consumed piece must match the issued bag order.
  int e;
  always @(negedge clk) begin
    if (started && !rst && pop_drv && bus.piece_valid === 1'b1) begin
      e = -1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("sb_piece", 32'(bus.piece), 32'(e));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic p, input logic r);
    pop_drv = p;
    rst     = r;
    @(posedge clk);
    #2;
  endtask

  int n;

  initial begin
    for (int i = 0; i < 7; i++) perm_bag[i] = 3'd0;
    pop_drv = 0;
    rst     = 1;
    @(posedge clk);
    #2;
    step(0, 1);        // E0: last edge with rst high
    rst = 0;

    // Startup: two bags fill the queue, first bag fixed.
    for (int i = 0; i < 16; i++) step(0, 0);
    check("startup_count", 32'(bus.count), 32'd14);
    check("startup_piece", 32'(bus.piece), 32'd3);
    check("startup_prev0", 32'(bus.preview[2:0]), 32'd1);
    check("startup_prev1", 32'(bus.preview[5:3]), 32'd7);
    check("startup_prev2", 32'(bus.preview[8:6]), 32'd5);

    // Pop every cycle.
    for (int i = 0; i < 40; i++) step(1, 0);

    // Hover at count 5 so pops coincide with refill writes.
    for (int i = 0; i < 120; i++)
      step((mq.size() > 5) || (mq.size() == 5 && left > 0 && left < 7), 0);

    // Random pops.
    for (int i = 0; i < 200; i++) step($urandom_range(3, 0) == 0, 0);

    // Duplicate value in one bag.
    forced = 2;
    for (n = 0; n < 300 && !(forced == 0 && left == 0); n++) step($urandom_range(1, 0) == 0, 0);
    check("dup_bag_seen", 32'(forced == 0 && left == 0), 32'd1);
    for (int i = 0; i < 10; i++) step($urandom_range(1, 0) == 0, 0);
    check("dup_err_sticky", 32'(bus.bag_err), 32'd1);
    step(0, 1);
    check("rst_err_clear", 32'(bus.bag_err), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);

    // Pop held from reset release: pops on empty queue, incl. first write cycle;
    // the first bag also carries a 0.
    forced = 3;
    for (int i = 0; i < 20; i++) step(1, 0);
    check("zero_err", 32'(bus.bag_err), 32'd1);
    step(0, 1);

    // Reset during READ index 3.
    for (n = 0; n < 300 && left != 4; n++) step($urandom_range(3, 0) == 0, 0);
    check("reach_read3", 32'(left), 32'd4);
    step(0, 1);
    check("midbag_count", 32'(bus.count), 32'd0);
    check("midbag_valid", 32'(bus.piece_valid), 32'd0);
    step(0, 0);
    check("midbag_relatch", 32'(bus.perm_latch), 32'd1);
    for (int i = 0; i < 60; i++) step($urandom_range(2, 0) == 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
